// File: rtl/fetch_pc_pkg.sv
// Shared types and sizing helpers for the fetch PC generator slice.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package fetch_pc_pkg;

  // BTB entry fields are sized for this address width.
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fsm_state_t;

  // The slot field is wide enough for the largest fetch group (8 slots).
  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] tag;
    logic [2:0]          slot;
    logic [XLEN_DEF-1:0] target;
  } btb_entry_t;

  // Bytes covered by one fetch group.
  function automatic int fetch_bytes(input int fetch_w);
    return fetch_w * 4;
  endfunction

  // Width of a slot index. The minimum is one bit, even for single-slot groups.
  function automatic int slot_w(input int fetch_w);
    return (fetch_w > 1) ? $clog2(fetch_w) : 1;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-group handshake between the PC generator (master) and the fetch queue (slave).
// Latency: wires only.
// Backpressure: the slave holds fetch_ready low to stall; the master keeps the group stable.
interface fetch_pc_gen_if
  import fetch_pc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int FETCH_W = 2
) ();

  localparam int SW = slot_w(FETCH_W);

  logic               fetch_valid;
  logic               fetch_ready;
  logic [XLEN-1:0]    fetch_pc;
  logic [FETCH_W-1:0] fetch_mask;
  logic               fetch_pred_taken;
  logic [SW-1:0]      fetch_pred_slot;
  logic [XLEN-1:0]    fetch_pred_target;

  modport master (
    output fetch_valid, fetch_pc, fetch_mask,
    output fetch_pred_taken, fetch_pred_slot, fetch_pred_target,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_mask,
    input  fetch_pred_taken, fetch_pred_slot, fetch_pred_target,
    output fetch_ready
  );

endinterface

// File: rtl/fetch_pc_btb.sv
// Direct-mapped branch target buffer, indexed by fetch-group address.
// Latency: the lookup is combinational; an update is written at the next clock edge.
// Backpressure: none. A same-index lookup sees the contents from before the update.
module fetch_pc_btb
  import fetch_pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FETCH_W     = 2,
  parameter int BTB_ENTRIES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [XLEN-1:0]              lookup_pc,
  output logic                         hit,
  output logic [slot_w(FETCH_W)-1:0]   hit_slot,
  output logic [XLEN-1:0]              hit_target,
  input  logic                         upd_valid,
  input  logic                         upd_taken,
  input  logic [XLEN-1:0]              upd_pc,
  input  logic [XLEN-1:0]              upd_target
);

  localparam int SW = slot_w(FETCH_W);
  localparam int GB = $clog2(fetch_bytes(FETCH_W));
  localparam int IW = $clog2(BTB_ENTRIES);

  btb_entry_t mem [BTB_ENTRIES];

  logic [IW-1:0]       l_idx, u_idx;
  logic [XLEN_DEF-1:0] l_tag, u_tag;
  logic [2:0]          l_off, u_slot;
  btb_entry_t          rd;

  // Split the lookup and update addresses into index, tag and slot fields.
  always_comb begin
    l_idx  = lookup_pc[GB +: IW];
    l_tag  = XLEN_DEF'(lookup_pc >> (GB + IW));
    l_off  = 3'((lookup_pc >> 2) & XLEN'(FETCH_W - 1));
    u_idx  = upd_pc[GB +: IW];
    u_tag  = XLEN_DEF'(upd_pc >> (GB + IW));
    u_slot = 3'((upd_pc >> 2) & XLEN'(FETCH_W - 1));
  end

  // A branch that sits before the group entry point belongs to an earlier path, so it does not count as a hit.
  always_comb begin
    rd         = mem[l_idx];
    hit        = rd.valid && (rd.tag == l_tag) && (rd.slot >= l_off);
    hit_slot   = SW'(rd.slot);
    hit_target = XLEN'(rd.target);
  end

  // Reset flushes every entry. A taken update writes its entry; a not-taken update invalidates it only on a tag match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) mem[i] <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        mem[u_idx] <= '{valid: 1'b1, tag: u_tag, slot: u_slot, target: XLEN_DEF'(upd_target)};
      end else if (mem[u_idx].valid && (mem[u_idx].tag == u_tag)) begin
        mem[u_idx].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Program-counter generator: one aligned fetch group per handshake. Redirects take priority, then BTB predictions.
// Latency: a redirect at edge N presents the new group immediately after edge N.
// Backpressure: while fetch_valid & !fetch_ready, every fetch_* output holds, including the prediction.
// Optional BTB steering is enabled by defining FETCH_PC_BTB_EN.
module fetch_pc_gen
  import fetch_pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              FETCH_W     = 2,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_pc_gen_if.master  fetch,
  input  logic            upd_valid,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  output logic            halted
);

  localparam int              SW         = slot_w(FETCH_W);
  localparam int              FB         = fetch_bytes(FETCH_W);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] GROUP_MASK = ~XLEN'(FB - 1);

  fsm_state_t         state_q;
  logic [XLEN-1:0]    pc_q;
  logic               valid_q, halted_q;
  logic               lk_hit;
  logic [SW-1:0]      lk_slot;
  logic [XLEN-1:0]    lk_target;
  logic               hold_q, held_taken;
  logic [SW-1:0]      held_slot;
  logic [XLEN-1:0]    held_target;
  logic               pred_taken;
  logic [SW-1:0]      pred_slot;
  logic [XLEN-1:0]    pred_target;
  logic [SW-1:0]      off;
  logic [FETCH_W-1:0] mask;
  logic               fire;
  logic [XLEN-1:0]    seq_pc;

`ifdef FETCH_PC_BTB_EN
  fetch_pc_btb #(
    .XLEN(XLEN), .FETCH_W(FETCH_W), .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (pc_q),
    .hit        (lk_hit),
    .hit_slot   (lk_slot),
    .hit_target (lk_target),
    .upd_valid  (upd_valid),
    .upd_taken  (upd_taken),
    .upd_pc     (upd_pc),
    .upd_target (upd_target)
  );
`else
  logic unused_upd;
  assign unused_upd = ^{upd_valid, upd_taken, upd_pc, upd_target};
  assign lk_hit     = 1'b0;
  assign lk_slot    = '0;
  assign lk_target  = '0;
`endif

  // During a stall, use the prediction captured at the stall rather than a live lookup, so a BTB update cannot change a pending group.
  always_comb begin
    pred_taken  = 1'b0;
    pred_slot   = '0;
    pred_target = '0;
    if (valid_q) begin
      if (hold_q) begin
        pred_taken  = held_taken;
        pred_slot   = held_slot;
        pred_target = held_target;
      end else if (lk_hit) begin
        pred_taken  = 1'b1;
        pred_slot   = lk_slot;
        pred_target = lk_target;
      end
    end
  end

  // Slots before the entry offset and slots after a predicted-taken branch are not valid.
  always_comb begin
    off    = SW'((pc_q >> 2) & XLEN'(FETCH_W - 1));
    fire   = valid_q && fetch.fetch_ready;
    seq_pc = (pc_q & GROUP_MASK) + XLEN'(FB);
    mask   = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      mask[i] = valid_q && (i >= int'(off)) && (!pred_taken || (i <= int'(pred_slot)));
    end
  end

  assign fetch.fetch_valid       = valid_q;
  assign fetch.fetch_pc          = pc_q;
  assign fetch.fetch_mask        = mask;
  assign fetch.fetch_pred_taken  = pred_taken;
  assign fetch.fetch_pred_slot   = pred_slot;
  assign fetch.fetch_pred_target = pred_target;
  assign halted                  = halted_q;

  // Control FSM and PC register. A redirect beats everything; a group that fires in the same cycle counts as consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VEC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      state_q  <= RUN;
      pc_q     <= redirect_pc & ALIGN_MASK;
      valid_q  <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      if (fire) pc_q <= pred_taken ? (pred_target & ALIGN_MASK) : seq_pc;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (halt_req) begin
            state_q  <= HALTED;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        HALTED: ;
        default: begin
          state_q  <= BOOT;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture the presented prediction each cycle. It is replayed next cycle only if the group stays stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= 1'b0;
      held_taken  <= 1'b0;
      held_slot   <= '0;
      held_target <= '0;
    end else begin
      hold_q      <= valid_q && !fetch.fetch_ready && !redirect_valid && !halt_req;
      held_taken  <= pred_taken;
      held_slot   <= pred_slot;
      held_target <= pred_target;
    end
  end

endmodule
